// File: rtl/arbiter_nx1.sv
// N-to-1 AXI-Lite interconnect: N upstream masters share one downstream slave.
// Write and read paths have independent round-robin arbiters that hold their grant until the response handshake.
module arbiter_nx1 #(
    parameter int N          = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // upstream write address / data / response
    input  logic [N*ADDR_WIDTH-1:0]       s_aw_addr,
    input  logic [N-1:0]                  s_aw_valid,
    output logic [N-1:0]                  s_aw_ready,
    input  logic [N*DATA_WIDTH-1:0]       s_w_data,
    input  logic [N*(DATA_WIDTH/8)-1:0]   s_w_strb,
    input  logic [N-1:0]                  s_w_valid,
    output logic [N-1:0]                  s_w_ready,
    output logic [1:0]                    s_b_resp,
    output logic [N-1:0]                  s_b_valid,
    input  logic [N-1:0]                  s_b_ready,
    // upstream read address / data
    input  logic [N*ADDR_WIDTH-1:0]       s_ar_addr,
    input  logic [N-1:0]                  s_ar_valid,
    output logic [N-1:0]                  s_ar_ready,
    output logic [DATA_WIDTH-1:0]         s_r_data,
    output logic [1:0]                    s_r_resp,
    output logic [N-1:0]                  s_r_valid,
    input  logic [N-1:0]                  s_r_ready,
    // downstream slave port
    output logic [ADDR_WIDTH-1:0]         m_aw_addr,
    output logic                          m_aw_valid,
    input  logic                          m_aw_ready,
    output logic [DATA_WIDTH-1:0]         m_w_data,
    output logic [DATA_WIDTH/8-1:0]       m_w_strb,
    output logic                          m_w_valid,
    input  logic                          m_w_ready,
    input  logic [1:0]                    m_b_resp,
    input  logic                          m_b_valid,
    output logic                          m_b_ready,
    output logic [ADDR_WIDTH-1:0]         m_ar_addr,
    output logic                          m_ar_valid,
    input  logic                          m_ar_ready,
    input  logic [DATA_WIDTH-1:0]         m_r_data,
    input  logic [1:0]                    m_r_resp,
    input  logic                          m_r_valid,
    output logic                          m_r_ready,
    // debug visibility of both arbiters
    output logic [1:0]                    wr_state,
    output logic [1:0]                    rd_state,
    output logic [$clog2(N)-1:0]          wr_grant,
    output logic [$clog2(N)-1:0]          rd_grant,
    output logic [$clog2(N)-1:0]          wr_ptr,
    output logic [$clog2(N)-1:0]          rd_ptr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W      = $clog2(N);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2} wr_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_RESP = 2'd2} rd_state_t;

    // Handshake rule on every channel: a transfer happens in a cycle where valid and ready are
    // both high at the rising clock edge; valid never waits on ready.

    logic [ADDR_WIDTH-1:0] aw_addr_arr [N];
    logic [ADDR_WIDTH-1:0] ar_addr_arr [N];
    logic [DATA_WIDTH-1:0] w_data_arr  [N];
    logic [STRB_WIDTH-1:0] w_strb_arr  [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign aw_addr_arr[g] = s_aw_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign ar_addr_arr[g] = s_ar_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_data_arr[g]  = s_w_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_strb_arr[g]  = s_w_strb[g*STRB_WIDTH +: STRB_WIDTH];
    end

    // First requester at or after ptr, searching cyclically.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N-1:0] req, input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] pick;
        int idx;
        pick = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) pick = PTR_W'(idx);
        end
        return pick;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] g);
        return (int'(g) == N - 1) ? '0 : g + 1'b1;
    endfunction

    wr_state_t        w_state, w_state_next;
    logic [PTR_W-1:0] wgrant, wgrant_next, wptr, wptr_next;
    logic             aw_done, aw_done_next, w_done, w_done_next;
    logic             aw_fin, w_fin;

    rd_state_t        r_state, r_state_next;
    logic [PTR_W-1:0] rgrant, rgrant_next, rptr, rptr_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            wgrant  <= '0;
            wptr    <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            w_state <= w_state_next;
            wgrant  <= wgrant_next;
            wptr    <= wptr_next;
            aw_done <= aw_done_next;
            w_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = w_state;
        wgrant_next  = wgrant;
        wptr_next    = wptr;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        aw_fin       = 1'b0;
        w_fin        = 1'b0;
        s_aw_ready   = '0;
        s_w_ready    = '0;
        s_b_valid    = '0;
        m_aw_valid   = 1'b0;
        m_w_valid    = 1'b0;
        m_b_ready    = 1'b0;
        m_aw_addr    = aw_addr_arr[wgrant];
        m_w_data     = w_data_arr[wgrant];
        m_w_strb     = w_strb_arr[wgrant];
        case (w_state)
            W_IDLE: begin
                // Only AW requests arbitration; early W data waits for its AW.
                if (|s_aw_valid) begin
                    wgrant_next  = rr_pick(s_aw_valid, wptr);
                    w_state_next = W_ADDR;
                end
            end
            W_ADDR: begin
                m_aw_valid         = s_aw_valid[wgrant] & ~aw_done;
                m_w_valid          = s_w_valid[wgrant] & ~w_done;
                s_aw_ready[wgrant] = m_aw_ready & ~aw_done;
                s_w_ready[wgrant]  = m_w_ready & ~w_done;
                aw_fin             = aw_done | (s_aw_valid[wgrant] & m_aw_ready);
                w_fin              = w_done | (s_w_valid[wgrant] & m_w_ready);
                aw_done_next       = aw_fin;
                w_done_next        = w_fin;
                if (aw_fin && w_fin) w_state_next = W_RESP;
            end
            W_RESP: begin
                s_b_valid[wgrant] = m_b_valid;
                m_b_ready         = s_b_ready[wgrant];
                if (m_b_valid && s_b_ready[wgrant]) begin
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    wptr_next    = ptr_after(wgrant);
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            rgrant  <= '0;
            rptr    <= '0;
        end else begin
            r_state <= r_state_next;
            rgrant  <= rgrant_next;
            rptr    <= rptr_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        rgrant_next  = rgrant;
        rptr_next    = rptr;
        s_ar_ready   = '0;
        s_r_valid    = '0;
        m_ar_valid   = 1'b0;
        m_r_ready    = 1'b0;
        m_ar_addr    = ar_addr_arr[rgrant];
        case (r_state)
            R_IDLE: begin
                if (|s_ar_valid) begin
                    rgrant_next  = rr_pick(s_ar_valid, rptr);
                    r_state_next = R_ADDR;
                end
            end
            R_ADDR: begin
                m_ar_valid         = s_ar_valid[rgrant];
                s_ar_ready[rgrant] = m_ar_ready;
                if (s_ar_valid[rgrant] && m_ar_ready) r_state_next = R_RESP;
            end
            R_RESP: begin
                s_r_valid[rgrant] = m_r_valid;
                m_r_ready         = s_r_ready[rgrant];
                if (m_r_valid && s_r_ready[rgrant]) begin
                    rptr_next    = ptr_after(rgrant);
                    r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // Response payloads are broadcast; only the granted master's valid qualifies them.
    assign s_b_resp = m_b_resp;
    assign s_r_data = m_r_data;
    assign s_r_resp = m_r_resp;

    assign wr_state = w_state;
    assign rd_state = r_state;
    assign wr_grant = wgrant;
    assign rd_grant = rgrant;
    assign wr_ptr   = wptr;
    assign rd_ptr   = rptr;

endmodule

// File: tb/tb_arbiter_nx1.sv
// Directed bench for arbiter_nx1: a 2-master instance for protocol scenarios and a 4-master one for rotation order.
module tb_arbiter_nx1;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // 2-master instance
    logic [63:0] s_aw_addr, s_ar_addr, s_w_data;
    logic [7:0]  s_w_strb;
    logic [1:0]  s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
    logic [1:0]  s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, s_b_resp, s_r_resp;
    logic [31:0] s_r_data;
    logic [31:0] m_aw_addr, m_w_data, m_ar_addr, m_r_data;
    logic [3:0]  m_w_strb;
    logic        m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
    logic        m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
    logic [1:0]  m_b_resp, m_r_resp, wr_state, rd_state;
    logic        wr_grant, rd_grant, wr_ptr, rd_ptr;

    // 4-master instance
    logic [127:0] s_aw_addr_4, s_ar_addr_4, s_w_data_4;
    logic [15:0]  s_w_strb_4;
    logic [3:0]   s_aw_valid_4, s_aw_ready_4, s_w_valid_4, s_w_ready_4, s_b_valid_4, s_b_ready_4;
    logic [3:0]   s_ar_valid_4, s_ar_ready_4, s_r_valid_4, s_r_ready_4;
    logic [1:0]   s_b_resp_4, s_r_resp_4, m_b_resp_4, m_r_resp_4, wr_state_4, rd_state_4;
    logic [31:0]  s_r_data_4, m_aw_addr_4, m_w_data_4, m_ar_addr_4, m_r_data_4;
    logic [3:0]   m_w_strb_4;
    logic         m_aw_valid_4, m_aw_ready_4, m_w_valid_4, m_w_ready_4, m_b_valid_4, m_b_ready_4;
    logic         m_ar_valid_4, m_ar_ready_4, m_r_valid_4, m_r_ready_4;
    logic [1:0]   wr_grant_4, rd_grant_4, wr_ptr_4, rd_ptr_4;

    arbiter_nx1 #(.N(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_aw_addr(s_aw_addr), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
        .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
        .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
        .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
        .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
        .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
        .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
        .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
        .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
        .wr_state(wr_state), .rd_state(rd_state), .wr_grant(wr_grant), .rd_grant(rd_grant),
        .wr_ptr(wr_ptr), .rd_ptr(rd_ptr)
    );

    arbiter_nx1 #(.N(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .s_aw_addr(s_aw_addr_4), .s_aw_valid(s_aw_valid_4), .s_aw_ready(s_aw_ready_4),
        .s_w_data(s_w_data_4), .s_w_strb(s_w_strb_4), .s_w_valid(s_w_valid_4), .s_w_ready(s_w_ready_4),
        .s_b_resp(s_b_resp_4), .s_b_valid(s_b_valid_4), .s_b_ready(s_b_ready_4),
        .s_ar_addr(s_ar_addr_4), .s_ar_valid(s_ar_valid_4), .s_ar_ready(s_ar_ready_4),
        .s_r_data(s_r_data_4), .s_r_resp(s_r_resp_4), .s_r_valid(s_r_valid_4), .s_r_ready(s_r_ready_4),
        .m_aw_addr(m_aw_addr_4), .m_aw_valid(m_aw_valid_4), .m_aw_ready(m_aw_ready_4),
        .m_w_data(m_w_data_4), .m_w_strb(m_w_strb_4), .m_w_valid(m_w_valid_4), .m_w_ready(m_w_ready_4),
        .m_b_resp(m_b_resp_4), .m_b_valid(m_b_valid_4), .m_b_ready(m_b_ready_4),
        .m_ar_addr(m_ar_addr_4), .m_ar_valid(m_ar_valid_4), .m_ar_ready(m_ar_ready_4),
        .m_r_data(m_r_data_4), .m_r_resp(m_r_resp_4), .m_r_valid(m_r_valid_4), .m_r_ready(m_r_ready_4),
        .wr_state(wr_state_4), .rd_state(rd_state_4), .wr_grant(wr_grant_4), .rd_grant(rd_grant_4),
        .wr_ptr(wr_ptr_4), .rd_ptr(rd_ptr_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven and outputs sampled there.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_bv;
        int         exp_m;
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        s_aw_addr = '0; s_ar_addr = '0; s_w_data = '0; s_w_strb = '0;
        s_aw_valid = '0; s_w_valid = '0; s_b_ready = '0; s_ar_valid = '0; s_r_ready = '0;
        m_aw_ready = 1'b0; m_w_ready = 1'b0; m_b_resp = '0; m_b_valid = 1'b0;
        m_ar_ready = 1'b0; m_r_data = '0; m_r_resp = '0; m_r_valid = 1'b0;
        s_aw_addr_4 = '0; s_ar_addr_4 = '0; s_w_data_4 = '0; s_w_strb_4 = '0;
        s_aw_valid_4 = '0; s_w_valid_4 = '0; s_b_ready_4 = '0; s_ar_valid_4 = '0; s_r_ready_4 = '0;
        m_aw_ready_4 = 1'b0; m_w_ready_4 = 1'b0; m_b_resp_4 = '0; m_b_valid_4 = 1'b0;
        m_ar_ready_4 = 1'b0; m_r_data_4 = '0; m_r_resp_4 = '0; m_r_valid_4 = 1'b0;

        // Reset state
        cyc(); cyc();
        chk("rst_wr_state", wr_state, 2'd0);
        chk("rst_rd_state", rd_state, 2'd0);
        chk("rst_wr_ptr", wr_ptr, 1'b0);
        chk("rst_m_aw_valid", m_aw_valid, 1'b0);
        chk("rst_m_b_ready", m_b_ready, 1'b0);
        chk("rst_s_aw_ready", s_aw_ready, 2'b00);
        rst_n = 1'b1;
        cyc();

        // 1: master 1 alone writes 0x10 / A5A5A5A5 / F
        s_aw_addr[63:32] = 32'h10; s_aw_valid = 2'b10;
        s_w_data[63:32] = 32'hA5A5A5A5; s_w_strb[7:4] = 4'hF; s_w_valid = 2'b10;
        #1;
        chk("t1_idle_no_aw", m_aw_valid, 1'b0);
        cyc();
        chk("t1_aw_valid", m_aw_valid, 1'b1);
        chk("t1_aw_addr", m_aw_addr, 32'h10);
        chk("t1_w_data", m_w_data, 32'hA5A5A5A5);
        chk("t1_w_strb", m_w_strb, 4'hF);
        chk("t1_wr_grant", wr_grant, 1'b1);
        chk("t1_aw_ready_wait", s_aw_ready, 2'b00);
        m_aw_ready = 1'b1; m_w_ready = 1'b1;
        #1;
        chk("t1_s_aw_ready", s_aw_ready, 2'b10);
        chk("t1_s_w_ready", s_w_ready, 2'b10);
        cyc();
        s_aw_valid = '0; s_w_valid = '0; m_aw_ready = 1'b0; m_w_ready = 1'b0;
        chk("t1_in_resp", wr_state, 2'd2);
        m_b_valid = 1'b1; m_b_resp = 2'b00; s_b_ready = 2'b10;
        #1;
        chk("t1_s_b_valid", s_b_valid, 2'b10);
        chk("t1_s_b_resp", s_b_resp, 2'b00);
        chk("t1_m_b_ready", m_b_ready, 1'b1);
        cyc();
        m_b_valid = 1'b0; s_b_ready = '0;
        #1;
        chk("t1_back_idle", wr_state, 2'd0);
        chk("t1_wr_ptr", wr_ptr, 1'b0);
        chk("t1_b_valid_off", s_b_valid, 2'b00);

        // 2: both masters request together; 0 then 1 with one IDLE cycle between
        s_aw_addr = {32'h30, 32'h20}; s_aw_valid = 2'b11;
        s_w_data = {32'h33333333, 32'h22222222}; s_w_strb = 8'hFF; s_w_valid = 2'b11;
        m_aw_ready = 1'b1; m_w_ready = 1'b1;
        cyc();
        chk("t2_first_addr", m_aw_addr, 32'h20);
        chk("t2_first_ready", s_aw_ready, 2'b01);
        chk("t2_first_wdata", m_w_data, 32'h22222222);
        cyc();
        s_aw_valid = 2'b10; s_w_valid = 2'b10;
        m_b_valid = 1'b1; m_b_resp = 2'b00; s_b_ready = 2'b11;
        #1;
        chk("t2_first_b", s_b_valid, 2'b01);
        cyc();
        m_b_valid = 1'b0;
        #1;
        chk("t2_gap_idle", wr_state, 2'd0);
        chk("t2_gap_no_aw", m_aw_valid, 1'b0);
        cyc();
        chk("t2_second_valid", m_aw_valid, 1'b1);
        chk("t2_second_addr", m_aw_addr, 32'h30);
        cyc();
        s_aw_valid = '0; s_w_valid = '0;
        m_b_valid = 1'b1; m_b_resp = 2'b10;
        #1;
        chk("t2_second_b", s_b_valid, 2'b10);
        chk("t2_resp_pass", s_b_resp, 2'b10);
        cyc();
        m_b_valid = 1'b0; s_b_ready = '0; m_aw_ready = 1'b0; m_w_ready = 1'b0; m_b_resp = '0;
        #1;
        chk("t2_ptr_wrap", wr_ptr, 1'b0);

        // 4: W presented three cycles before AW; slave takes W first
        s_aw_addr = {32'h0, 32'h40};
        s_w_data = {32'h0, 32'h11223344}; s_w_strb = 8'h0F; s_w_valid = 2'b01;
        cyc();
        chk("t4_w_only_idle", wr_state, 2'd0);
        chk("t4_w_only_no_fwd", m_w_valid, 1'b0);
        cyc(); cyc();
        s_aw_valid = 2'b01;
        cyc();
        m_w_ready = 1'b1;
        #1;
        chk("t4_w_fwd", m_w_valid, 1'b1);
        chk("t4_aw_fwd", m_aw_valid, 1'b1);
        chk("t4_s_w_ready", s_w_ready, 2'b01);
        cyc();
        #1;
        chk("t4_w_gated", m_w_valid, 1'b0);
        chk("t4_w_ready_gated", s_w_ready, 2'b00);
        chk("t4_aw_still", m_aw_valid, 1'b1);
        chk("t4_in_addr", wr_state, 2'd1);
        cyc();
        chk("t4_aw_hold", m_aw_valid, 1'b1);
        m_aw_ready = 1'b1;
        #1;
        chk("t4_s_aw_ready", s_aw_ready, 2'b01);
        cyc();
        s_aw_valid = '0; s_w_valid = '0; m_aw_ready = 1'b0; m_w_ready = 1'b0;
        #1;
        chk("t4_in_resp", wr_state, 2'd2);
        chk("t4_aw_off", m_aw_valid, 1'b0);
        m_b_valid = 1'b1; s_b_ready = 2'b01;
        cyc();
        m_b_valid = 1'b0; s_b_ready = '0;
        #1;
        chk("t4_wr_ptr", wr_ptr, 1'b1);

        // 5: write by master 0 with held B while master 1 reads
        s_aw_addr = {32'h70, 32'h50}; s_aw_valid = 2'b01; s_w_valid = 2'b01;
        s_ar_addr = {32'h60, 32'h0}; s_ar_valid = 2'b10;
        m_aw_ready = 1'b1; m_w_ready = 1'b1; m_ar_ready = 1'b1;
        cyc();
        chk("t5_wr_grant", wr_grant, 1'b0);
        chk("t5_ar_addr", m_ar_addr, 32'h60);
        chk("t5_s_ar_ready", s_ar_ready, 2'b10);
        cyc();
        s_aw_valid = 2'b10; s_w_valid = '0; s_ar_valid = '0;
        m_aw_ready = 1'b0; m_w_ready = 1'b0; m_ar_ready = 1'b0;
        m_b_valid = 1'b1; s_b_ready = 2'b00;
        m_r_valid = 1'b1; m_r_data = 32'hDEADBEEF; m_r_resp = 2'b00; s_r_ready = 2'b10;
        #1;
        chk("t5_s_r_valid", s_r_valid, 2'b10);
        chk("t5_s_r_data", s_r_data, 32'hDEADBEEF);
        chk("t5_m_r_ready", m_r_ready, 1'b1);
        chk("t5_s_b_valid", s_b_valid, 2'b01);
        chk("t5_b_held", m_b_ready, 1'b0);
        cyc();
        m_r_valid = 1'b0; s_r_ready = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t5_rd_idle", rd_state, 2'd0);
            chk("t5_wr_resp", wr_state, 2'd2);
            chk("t5_grant_stable", wr_grant, 1'b0);
            chk("t5_no_new_aw", m_aw_valid, 1'b0);
            cyc();
        end
        s_b_ready = 2'b01;
        #1;
        chk("t5_b_release", m_b_ready, 1'b1);
        cyc();
        s_b_ready = '0; m_b_valid = 1'b0;
        #1;
        chk("t5_idle_gap", m_aw_valid, 1'b0);
        cyc();
        chk("t5_new_aw_addr", m_aw_addr, 32'h70);
        chk("t5_new_grant", wr_grant, 1'b1);

        // 6: asynchronous reset while in W_RESP with B valid
        s_w_valid = 2'b10; m_aw_ready = 1'b1; m_w_ready = 1'b1;
        cyc();
        s_aw_valid = '0; s_w_valid = '0; m_aw_ready = 1'b0; m_w_ready = 1'b0;
        m_b_valid = 1'b1; s_b_ready = 2'b10;
        #1;
        chk("t6_pre_b_valid", s_b_valid, 2'b10);
        chk("t6_pre_b_ready", m_b_ready, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_b_valid", s_b_valid, 2'b00);
        chk("t6_async_b_ready", m_b_ready, 1'b0);
        chk("t6_async_state", wr_state, 2'd0);
        chk("t6_async_ptr", wr_ptr, 1'b0);
        m_b_valid = 1'b0; s_b_ready = '0;
        cyc();
        rst_n = 1'b1;
        s_aw_addr = {32'h90, 32'h80}; s_aw_valid = 2'b11;
        cyc();
        chk("t6_lowest_grant", wr_grant, 1'b0);
        chk("t6_lowest_addr", m_aw_addr, 32'h80);
        chk("t6_no_stale_b", s_b_valid, 2'b00);
        s_aw_valid = '0;

        // 3: four masters requesting continuously rotate 0,1,2,3,0,1,2,3
        for (int i = 0; i < 4; i++) begin
            s_aw_addr_4[i*32 +: 32] = 32'h100 + 32'(i);
            s_w_data_4[i*32 +: 32] = 32'hC0DE0000 + 32'(i);
        end
        s_w_strb_4 = 16'hFFFF; s_aw_valid_4 = 4'hF; s_w_valid_4 = 4'hF;
        m_aw_ready_4 = 1'b1; m_w_ready_4 = 1'b1; s_b_ready_4 = 4'hF;
        for (int j = 0; j < 8; j++) begin
            exp_m = j % 4;
            for (int k = 0; k < 8 && !m_aw_valid_4; k++) cyc();
            chk("t3_aw_valid", m_aw_valid_4, 1'b1);
            chk("t3_order_addr", m_aw_addr_4, 32'h100 + 32'(exp_m));
            cyc();
            m_b_valid_4 = 1'b1;
            exp_bv = 4'b0001 << exp_m;
            #1;
            chk("t3_b_valid", s_b_valid_4, exp_bv);
            cyc();
            m_b_valid_4 = 1'b0;
            #1;
        end
        s_aw_valid_4 = '0; s_w_valid_4 = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
